// File: rtl/laneswitch_ctrl.sv
// Two-lane shared-memory ownership controller: grants one lane at a time and drains in-flight traffic before swapping.
// Optional swap_count statistics port is enabled by defining LANESWITCH_CTRL_STATS_EN.
module laneswitch_ctrl #(
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 lane0_req,
   input  logic                 lane0_done,
   input  logic                 lane1_req,
   input  logic                 lane1_done,
   input  logic                 active,
   input  logic                 fault,
   output logic                 switch,
   output logic                 lane0_grant,
   output logic                 lane1_grant,
   output logic                 busy,
   output logic                 fault_seen
`ifdef LANESWITCH_CTRL_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0] swap_count
`endif
);

   typedef enum logic [2:0] {REL0, OWN0, DRAIN01, OWN1, REL1, DRAIN10} state_t;

   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

   state_t     state;
   logic [3:0] drain_cnt;

   if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 || CNT_WIDTH < 1) begin : g_bad_param
      $error("laneswitch_ctrl: DRAIN_CYCLES must be 1..15 and CNT_WIDTH >= 1");
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= REL0;
         drain_cnt   <= '0;
         switch      <= 1'b0;
         lane0_grant <= 1'b0;
         lane1_grant <= 1'b0;
         busy        <= 1'b0;
         fault_seen  <= 1'b0;
`ifdef LANESWITCH_CTRL_STATS_EN
         swap_count  <= '0;
`endif
      end else begin
         fault_seen <= fault_seen | fault;
         case (state)
            // The lane that did not own last gets priority when both request.
            REL0: begin
               if (lane1_req) begin
                  state     <= DRAIN01;
                  drain_cnt <= DRAIN_LOAD;
                  busy      <= 1'b1;
               end else if (lane0_req) begin
                  state       <= OWN0;
                  lane0_grant <= 1'b1;
               end
            end
            OWN0: begin
               if (lane0_done) begin
                  state       <= REL0;
                  lane0_grant <= 1'b0;
               end
            end
            DRAIN01: begin
               if (active) begin
                  drain_cnt <= DRAIN_LOAD;
               end else if (drain_cnt == 4'd1) begin
                  state       <= OWN1;
                  switch      <= 1'b1;
                  lane1_grant <= 1'b1;
                  busy        <= 1'b0;
`ifdef LANESWITCH_CTRL_STATS_EN
                  swap_count  <= swap_count + 1'b1;
`endif
               end else begin
                  drain_cnt <= drain_cnt - 4'd1;
               end
            end
            REL1: begin
               if (lane0_req) begin
                  state     <= DRAIN10;
                  drain_cnt <= DRAIN_LOAD;
                  busy      <= 1'b1;
               end else if (lane1_req) begin
                  state       <= OWN1;
                  lane1_grant <= 1'b1;
               end
            end
            OWN1: begin
               if (lane1_done) begin
                  state       <= REL1;
                  lane1_grant <= 1'b0;
               end
            end
            DRAIN10: begin
               if (active) begin
                  drain_cnt <= DRAIN_LOAD;
               end else if (drain_cnt == 4'd1) begin
                  state       <= OWN0;
                  switch      <= 1'b0;
                  lane0_grant <= 1'b1;
                  busy        <= 1'b0;
`ifdef LANESWITCH_CTRL_STATS_EN
                  swap_count  <= swap_count + 1'b1;
`endif
               end else begin
                  drain_cnt <= drain_cnt - 4'd1;
               end
            end
            default: begin
               state       <= REL0;
               switch      <= 1'b0;
               lane0_grant <= 1'b0;
               lane1_grant <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_laneswitch_ctrl.sv
// Self-checking bench for laneswitch_ctrl: directed scenarios plus randomized traffic against a lane-ownership model.
module tb_laneswitch_ctrl;
   localparam int D  = 2;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic reset, lane0_req, lane0_done, lane1_req, lane1_done, active, fault;
   logic switch, lane0_grant, lane1_grant, busy, fault_seen;
`ifdef LANESWITCH_CTRL_STATS_EN
   logic [CW-1:0] swap_count;
`endif

   int checks = 0;
   int errors = 0;

   // Model: which lane is selected, whether it holds the grant, and any drain in progress.
   bit m_sel, m_granted, m_drain, m_fs;
   int m_rem, m_swaps;

   laneswitch_ctrl #(.DRAIN_CYCLES(D), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .lane0_req(lane0_req), .lane0_done(lane0_done),
      .lane1_req(lane1_req), .lane1_done(lane1_done),
      .active(active), .fault(fault),
      .switch(switch), .lane0_grant(lane0_grant), .lane1_grant(lane1_grant),
      .busy(busy), .fault_seen(fault_seen)
`ifdef LANESWITCH_CTRL_STATS_EN
      , .swap_count(swap_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      lane0_req = 0; lane0_done = 0; lane1_req = 0; lane1_done = 0; active = 0; fault = 0;
   endtask

   task automatic model_reset();
      m_sel = 0; m_granted = 0; m_drain = 0; m_fs = 0; m_rem = 0; m_swaps = 0;
   endtask

   // Advance one rising edge; the model consumes the inputs the DUT samples on that edge.
   task automatic step();
      bit own_req, other_req, own_done;
      own_req   = m_sel ? lane1_req : lane0_req;
      other_req = m_sel ? lane0_req : lane1_req;
      own_done  = m_sel ? lane1_done : lane0_done;
      m_fs = m_fs | fault;
      if (m_drain) begin
         if (active) m_rem = D;
         else if (m_rem == 1) begin
            m_drain = 0; m_sel = !m_sel; m_granted = 1; m_swaps++;
         end else m_rem--;
      end else if (m_granted) begin
         if (own_done) m_granted = 0;
      end else if (other_req) begin
         m_drain = 1; m_rem = D;
      end else if (own_req) begin
         m_granted = 1;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1;
      lane0_req = 1; lane1_req = 1; active = 1; fault = 1;
      #1;
      checks++; if ({switch, lane0_grant, lane1_grant, busy, fault_seen} !== 5'b0)
         $display("FAIL reset_async: got %b want 00000", {switch, lane0_grant, lane1_grant, busy, fault_seen});
      @(posedge clk); #1;
      checks++; if ({switch, lane0_grant, lane1_grant, busy, fault_seen} !== 5'b0)
         $display("FAIL reset_held: got %b want 00000", {switch, lane0_grant, lane1_grant, busy, fault_seen});
`ifdef LANESWITCH_CTRL_STATS_EN
      checks++; if (swap_count !== '0) begin errors++; $display("FAIL reset_swap: got %0d want 0", swap_count); end
`endif
      if ({switch, lane0_grant, lane1_grant, busy, fault_seen} !== 5'b0) errors++;
      clear_inputs();
      reset = 0;
      model_reset();
   endtask

   task automatic test_own0();
      lane0_req = 1; step(); lane0_req = 0;
      checks++; if ({lane0_grant, lane1_grant, switch, busy} !== 4'b1000) begin
         errors++; $display("FAIL own0: got g0g1swbusy=%b want 1000", {lane0_grant, lane1_grant, switch, busy}); end
   endtask

   task automatic test_handoff();
      lane0_done = 1; step(); lane0_done = 0;
      checks++; if (lane0_grant !== 1'b0) begin errors++; $display("FAIL release0: got %b want 0", lane0_grant); end
      lane1_req = 1; active = 0; step(); lane1_req = 0;
      checks++; if ({busy, switch, lane0_grant, lane1_grant} !== 4'b1000) begin
         errors++; $display("FAIL handoff_n: got busy/sw/g0/g1=%b want 1000", {busy, switch, lane0_grant, lane1_grant}); end
      step();
      checks++; if ({busy, switch, lane1_grant} !== 3'b100) begin
         errors++; $display("FAIL handoff_n1: got busy/sw/g1=%b want 100", {busy, switch, lane1_grant}); end
      step();
      checks++; if ({busy, switch, lane0_grant, lane1_grant} !== 4'b0101) begin
         errors++; $display("FAIL handoff_n2: got busy/sw/g0/g1=%b want 0101", {busy, switch, lane0_grant, lane1_grant}); end
`ifdef LANESWITCH_CTRL_STATS_EN
      checks++; if (swap_count !== CW'(1)) begin errors++; $display("FAIL handoff_swap: got %0d want 1", swap_count); end
`endif
   endtask

   task automatic test_reload();
      do_reset();
      lane1_req = 1; step(); lane1_req = 0;
      step();
      active = 1; step(); active = 0;
      checks++; if ({busy, switch, lane1_grant} !== 3'b100) begin
         errors++; $display("FAIL reload_hold: got busy/sw/g1=%b want 100", {busy, switch, lane1_grant}); end
      step();
      checks++; if ({busy, switch, lane1_grant} !== 3'b100) begin
         errors++; $display("FAIL reload_wait: got busy/sw/g1=%b want 100", {busy, switch, lane1_grant}); end
      step();
      checks++; if ({busy, switch, lane1_grant} !== 3'b011) begin
         errors++; $display("FAIL reload_done: got busy/sw/g1=%b want 011", {busy, switch, lane1_grant}); end
   endtask

   task automatic test_alternation();
      do_reset();
      lane0_req = 1; lane1_req = 1;
      step();
      checks++; if ({busy, lane0_grant} !== 2'b10) begin
         errors++; $display("FAIL alt_drain01: got busy/g0=%b want 10", {busy, lane0_grant}); end
      step(); step();
      checks++; if ({switch, lane0_grant, lane1_grant} !== 3'b101) begin
         errors++; $display("FAIL alt_own1: got sw/g0/g1=%b want 101", {switch, lane0_grant, lane1_grant}); end
      lane1_done = 1; step(); lane1_done = 0;
      checks++; if ({switch, lane1_grant, busy} !== 3'b100) begin
         errors++; $display("FAIL alt_rel1: got sw/g1/busy=%b want 100", {switch, lane1_grant, busy}); end
      step();
      checks++; if ({switch, busy, lane0_grant, lane1_grant} !== 4'b1100) begin
         errors++; $display("FAIL alt_drain10: got sw/busy/g0/g1=%b want 1100", {switch, busy, lane0_grant, lane1_grant}); end
      step(); step();
      checks++; if ({switch, busy, lane0_grant, lane1_grant} !== 4'b0010) begin
         errors++; $display("FAIL alt_own0: got sw/busy/g0/g1=%b want 0010", {switch, busy, lane0_grant, lane1_grant}); end
      lane1_done = 1; step(); lane1_done = 0;
      checks++; if ({lane0_grant, busy} !== 2'b10) begin
         errors++; $display("FAIL foreign_done: got g0/busy=%b want 10", {lane0_grant, busy}); end
      lane0_req = 0; lane1_req = 0;
   endtask

   task automatic test_fault_reset();
      do_reset();
      fault = 1; lane1_req = 1; step(); fault = 0; lane1_req = 0;
      checks++; if (fault_seen !== 1'b1) begin errors++; $display("FAIL fault_set: got %b want 1", fault_seen); end
      step(); step();
      lane1_done = 1; step(); lane1_done = 0;
      lane0_req = 1; step(); lane0_req = 0;
      checks++; if ({busy, switch, fault_seen} !== 3'b111) begin
         errors++; $display("FAIL fault_sticky_drain10: got busy/sw/fs=%b want 111", {busy, switch, fault_seen}); end
      #2 reset = 1;
      #1;
      checks++; if ({switch, lane0_grant, lane1_grant, busy, fault_seen} !== 5'b0) begin
         errors++; $display("FAIL async_mid_drain: got %b want 00000", {switch, lane0_grant, lane1_grant, busy, fault_seen}); end
`ifdef LANESWITCH_CTRL_STATS_EN
      checks++; if (swap_count !== '0) begin errors++; $display("FAIL async_swap: got %0d want 0", swap_count); end
`endif
      #2 reset = 0;
      model_reset();
      step();
      checks++; if ({switch, busy, lane0_grant, lane1_grant} !== 4'b0) begin
         errors++; $display("FAIL post_reset_rel0: got %b want 0000", {switch, busy, lane0_grant, lane1_grant}); end
   endtask

   task automatic test_wrap();
`ifdef LANESWITCH_CTRL_STATS_EN
      do_reset();
      for (int i = 0; i < 16; i++) begin
         if (m_sel) lane0_req = 1; else lane1_req = 1;
         step(); lane0_req = 0; lane1_req = 0;
         for (int k = 0; k < D; k++) step();
         checks++; if (swap_count !== CW'((i + 1) % 16)) begin
            errors++; $display("FAIL wrap_%0d: got %0d want %0d", i, swap_count, (i + 1) % 16); end
         if (m_sel) lane1_done = 1; else lane0_done = 1;
         step(); lane0_done = 0; lane1_done = 0;
      end
`endif
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         lane0_req  = ($urandom_range(0, 1) == 1);
         lane1_req  = ($urandom_range(0, 1) == 1);
         lane0_done = ($urandom_range(0, 3) == 0);
         lane1_done = ($urandom_range(0, 3) == 0);
         active     = ($urandom_range(0, 9) < 3);
         fault      = ($urandom_range(0, 499) == 0);
         step();
         checks++; if (switch !== m_sel) begin errors++; $display("FAIL rnd_switch @%0d: got %b want %b", n, switch, m_sel); end
         checks++; if (lane0_grant !== (m_granted && !m_sel)) begin
            errors++; $display("FAIL rnd_grant0 @%0d: got %b want %b", n, lane0_grant, m_granted && !m_sel); end
         checks++; if (lane1_grant !== (m_granted && m_sel)) begin
            errors++; $display("FAIL rnd_grant1 @%0d: got %b want %b", n, lane1_grant, m_granted && m_sel); end
         checks++; if (busy !== m_drain) begin errors++; $display("FAIL rnd_busy @%0d: got %b want %b", n, busy, m_drain); end
         checks++; if (fault_seen !== m_fs) begin errors++; $display("FAIL rnd_fault_seen @%0d: got %b want %b", n, fault_seen, m_fs); end
         checks++; if (lane0_grant === 1'b1 && lane1_grant === 1'b1) begin
            errors++; $display("FAIL rnd_one_grant @%0d: got both 1 want at most one", n); end
`ifdef LANESWITCH_CTRL_STATS_EN
         checks++; if (swap_count !== CW'(m_swaps % (1 << CW))) begin
            errors++; $display("FAIL rnd_swap @%0d: got %0d want %0d", n, swap_count, m_swaps % (1 << CW)); end
`endif
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      model_reset();
      test_reset();
      test_own0();
      test_handoff();
      test_reload();
      test_alternation();
      test_fault_reset();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
